// File: rtl/jk_excite_driver_if.sv
// Handshake bundle for jk_excite_driver: offers one 8-bit target Q word.
// The master (producer) drives in_valid/in_data; the slave (driver) answers
// with in_ready, which is high only while the driver is idle.
interface jk_excite_driver_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: accepts an 8-bit target Q sequence and drives the J/K
// inputs of an external JK flip-flop so that its Q follows the sequence, MSB
// first, one bit per clock. Each driven bit is checked against the observed Q
// one cycle later. Mismatches raise a pulse and bump a saturating counter.
//
// Build option: define JK_TOGGLE_EN to make every required Q change use the
// toggle excitation (j=1,k=1) instead of the set/reset excitation.
module jk_excite_driver (
  input  logic                clk,
  input  logic                clr,
  jk_excite_driver_if.slave   inBus,
  input  logic                q_fb,
  output logic                j,
  output logic                k,
  output logic                busy,
  output logic                done,
  output logic                mismatch,
  output logic [7:0]          err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [7:0]  r_shiftReg;
  logic [2:0]  r_bitCnt;
  logic        r_expBit;
  logic        r_chkVld;
  logic        r_done;
  logic        r_mismatch;
  logic [7:0]  r_errCnt;

  logic        w_accept;
  logic        w_inReady;
  logic        w_busy;
  logic        w_driving;
  logic        w_target;
  logic        w_compareFail;
  logic        w_j;
  logic        w_k;

  // Pending comparison result: the bit driven last cycle should now be on Q.
  assign w_compareFail = r_chkVld && (q_fb != r_expBit);

  // The bit currently being driven is always the shift register MSB.
  assign w_target = r_shiftReg[7];

  // State register; clr forces IDLE regardless of any handshake.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and state-decoded control signals.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_inReady   = 1'b0;
    w_busy      = 1'b0;
    w_driving   = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (inBus.in_valid) begin
          w_accept    = 1'b1;
          w_nextState = DRIVE;
        end
      end
      DRIVE: begin
        w_busy    = 1'b1;
        w_driving = 1'b1;
        if (r_bitCnt == 3'd0) begin
          w_nextState = CHECK;
        end
      end
      CHECK: begin
        w_busy      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Excitation from the target bit and the observed Q; quiet outside DRIVE.
  always_comb begin
    w_j = 1'b0;
    w_k = 1'b0;
    if (w_driving) begin
`ifdef JK_TOGGLE_EN
      if (w_target != q_fb) begin
        w_j = 1'b1;
        w_k = 1'b1;
      end
`else
      if (w_target && !q_fb) begin
        w_j = 1'b1;
      end
      if (!w_target && q_fb) begin
        w_k = 1'b1;
      end
`endif
    end
  end

  // Word datapath: load on accept, shift out one bit per DRIVE cycle and
  // remember it so it can be compared against Q on the following edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_shiftReg <= 8'd0;
      r_bitCnt   <= 3'd0;
      r_expBit   <= 1'b0;
      r_chkVld   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shiftReg <= inBus.in_data;
            r_bitCnt   <= 3'd7;
          end
        end
        DRIVE: begin
          r_shiftReg <= {r_shiftReg[6:0], 1'b0};
          r_expBit   <= w_target;
          r_chkVld   <= 1'b1;
          r_bitCnt   <= r_bitCnt - 3'd1;
        end
        CHECK: begin
          r_chkVld <= 1'b0;
          r_done   <= 1'b1;
        end
        default: begin
          r_chkVld <= 1'b0;
        end
      endcase
    end
  end

  // Mismatch pulse and saturating error counter, fed by the pending compare.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_mismatch <= 1'b0;
      r_errCnt   <= 8'd0;
    end else begin
      r_mismatch <= w_compareFail;
      if (w_compareFail && (r_errCnt != 8'hFF)) begin
        r_errCnt <= r_errCnt + 8'd1;
      end
    end
  end

  assign inBus.in_ready = w_inReady;
  assign j              = w_j;
  assign k              = w_k;
  assign busy           = w_busy;
  assign done           = r_done;
  assign mismatch       = r_mismatch;
  assign err_cnt        = r_errCnt;

endmodule
